// File: rtl/sdc_ram_fifo_ctrl_if.sv
// Bus bundle between the FIFO controller, its two write requesters, its reader
// and the distributed RAM it drives.
interface sdc_ram_fifo_ctrl_if #(
  parameter int RAM_WIDTH     = 72,
  parameter int RAM_ADDR_BITS = 8
);
  logic                     flush;
  logic                     wr_req_a;
  logic [RAM_WIDTH-1:0]     wr_data_a;
  logic                     wr_gnt_a;
  logic                     wr_req_b;
  logic [RAM_WIDTH-1:0]     wr_data_b;
  logic                     wr_gnt_b;
  logic                     rd_valid;
  logic [RAM_WIDTH-1:0]     rd_data;
  logic                     rd_ack;
  logic [RAM_ADDR_BITS:0]   level;
  logic                     full;
  logic                     empty;
  logic                     ovf_err;
  logic                     udf_err;
  logic                     wr_ram_enb;
  logic [RAM_ADDR_BITS-1:0] wr_ram_addr;
  logic [RAM_WIDTH-1:0]     wr_ram_data;
  logic [RAM_ADDR_BITS-1:0] rd_ram_addr;
  logic [RAM_WIDTH-1:0]     output_ram_data;

  // Controller side
  modport slave (
    input  flush, wr_req_a, wr_data_a, wr_req_b, wr_data_b, rd_ack, output_ram_data,
    output wr_gnt_a, wr_gnt_b, rd_valid, rd_data, level, full, empty, ovf_err, udf_err,
           wr_ram_enb, wr_ram_addr, wr_ram_data, rd_ram_addr
  );

  // Environment side: requesters, reader and RAM
  modport master (
    output flush, wr_req_a, wr_data_a, wr_req_b, wr_data_b, rd_ack, output_ram_data,
    input  wr_gnt_a, wr_gnt_b, rd_valid, rd_data, level, full, empty, ovf_err, udf_err,
           wr_ram_enb, wr_ram_addr, wr_ram_data, rd_ram_addr
  );
endinterface

// File: rtl/sdc_ram_fifo_ctrl.sv
// Circular FIFO controller over a dual-port distributed RAM: round-robin write
// arbitration between the SD data path (A) and the host path (B), show-ahead read.
module sdc_ram_fifo_ctrl #(
  parameter int RAM_WIDTH     = 72,
  parameter int RAM_ADDR_BITS = 8
) (
  input logic              clk,
  input logic              reset_n,
  sdc_ram_fifo_ctrl_if.slave bus
);
  localparam int LVL_W = RAM_ADDR_BITS + 1;
  localparam logic [LVL_W-1:0] DEPTH = {1'b1, {RAM_ADDR_BITS{1'b0}}};

  logic [RAM_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [RAM_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic                     last_gnt_q, last_gnt_d;
  logic                     ovf_q, ovf_d;
  logic                     udf_q, udf_d;

  logic                     full_s;
  logic                     empty_s;
  logic                     gnt_a_s;
  logic                     gnt_b_s;
  logic                     wr_fire_s;
  logic                     rd_fire_s;
  logic [RAM_WIDTH-1:0]     wr_data_s;

  assign full_s    = (level_q == DEPTH);
  assign empty_s   = (level_q == {LVL_W{1'b0}});
  assign wr_fire_s = gnt_a_s | gnt_b_s;
  // A flush discards any same-cycle read; reading an empty FIFO is an error, not a pop.
  assign rd_fire_s = bus.rd_ack & ~empty_s & ~bus.flush;

  // Round-robin grant of the single RAM write port
  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    if (reset_n && !bus.flush && !full_s) begin
      case ({bus.wr_req_a, bus.wr_req_b})
        2'b11: begin
          if (last_gnt_q) begin
            gnt_a_s = 1'b1;
          end else begin
            gnt_b_s = 1'b1;
          end
        end
        2'b10:   gnt_a_s = 1'b1;
        2'b01:   gnt_b_s = 1'b1;
        default: begin
          gnt_a_s = 1'b0;
          gnt_b_s = 1'b0;
        end
      endcase
    end else begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
    end
  end

  // Write data mux from the granted requester
  always_comb begin
    wr_data_s = bus.wr_data_a;
    if (gnt_b_s) begin
      wr_data_s = bus.wr_data_b;
    end else begin
      wr_data_s = bus.wr_data_a;
    end
  end

  // Next-state for pointers, occupancy, arbitration history and sticky errors
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    last_gnt_d = last_gnt_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    if (bus.flush) begin
      wr_ptr_d = {RAM_ADDR_BITS{1'b0}};
      rd_ptr_d = {RAM_ADDR_BITS{1'b0}};
      level_d  = {LVL_W{1'b0}};
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_fire_s) begin
        wr_ptr_d   = wr_ptr_q + {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};
        last_gnt_d = gnt_b_s;
      end else begin
        wr_ptr_d   = wr_ptr_q;
        last_gnt_d = last_gnt_q;
      end
      if (rd_fire_s) begin
        rd_ptr_d = rd_ptr_q + {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_fire_s, rd_fire_s})
        2'b10:   level_d = level_q + {{(LVL_W-1){1'b0}}, 1'b1};
        2'b01:   level_d = level_q - {{(LVL_W-1){1'b0}}, 1'b1};
        default: level_d = level_q;
      endcase
      ovf_d = ovf_q | ((bus.wr_req_a | bus.wr_req_b) & full_s);
      udf_d = udf_q | (bus.rd_ack & empty_s);
    end
  end

  // State registers; last_gnt resets to B so A wins the first tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= {RAM_ADDR_BITS{1'b0}};
      rd_ptr_q   <= {RAM_ADDR_BITS{1'b0}};
      level_q    <= {LVL_W{1'b0}};
      last_gnt_q <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      last_gnt_q <= last_gnt_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign bus.wr_gnt_a    = gnt_a_s;
  assign bus.wr_gnt_b    = gnt_b_s;
  assign bus.wr_ram_enb  = wr_fire_s;
  assign bus.wr_ram_addr = wr_ptr_q;
  assign bus.wr_ram_data = wr_data_s;
  assign bus.rd_ram_addr = rd_ptr_q;
  assign bus.rd_data     = bus.output_ram_data;
  assign bus.rd_valid    = ~empty_s;
  assign bus.level       = level_q;
  assign bus.full        = full_s;
  assign bus.empty       = empty_s;
  assign bus.ovf_err     = ovf_q;
  assign bus.udf_err     = udf_q;
endmodule

// File: tb/tb_sdc_ram_fifo_ctrl.sv
// Directed bench for sdc_ram_fifo_ctrl: a negedge monitor keeps a behavioural
// FIFO model and a scoreboard queue of written words, plus hand-computed spot checks.
module tb_sdc_ram_fifo_ctrl;
  logic clk;
  logic reset_n;

  sdc_ram_fifo_ctrl_if #(.RAM_WIDTH(72), .RAM_ADDR_BITS(8)) ifc ();

  sdc_ram_fifo_ctrl #(.RAM_WIDTH(72), .RAM_ADDR_BITS(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  // Behavioural RAM: synchronous write, asynchronous read
  logic [71:0] mem [256];
  always @(posedge clk) begin
    if (ifc.wr_ram_enb) mem[ifc.wr_ram_addr] <= ifc.wr_ram_data;
  end
  assign ifc.output_ram_data = mem[ifc.rd_ram_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  string       hn_q [$];
  logic [71:0] ha_q [$];
  logic [71:0] he_q [$];
  logic [71:0] exp_q [$];

  int m_wr, m_rd, m_lvl;
  bit m_last, m_ovf, m_udf;

  task automatic cmp(input string n, input logic [71:0] act, input logic [71:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  task automatic hc(input string n, input logic [71:0] act, input logic [71:0] exp);
    hn_q.push_back(n);
    ha_q.push_back(act);
    he_q.push_back(exp);
  endtask

  // Monitor: drain spot checks, compare against model, advance model for the coming edge
  always @(negedge clk) begin
    bit ea, eb, fullm, emptym, rd;
    logic [71:0] front;
    while (hn_q.size() > 0) cmp(hn_q.pop_front(), ha_q.pop_front(), he_q.pop_front());
    if (!reset_n) begin
      m_wr = 0; m_rd = 0; m_lvl = 0; m_last = 1'b1; m_ovf = 1'b0; m_udf = 1'b0;
      exp_q.delete();
    end else begin
      fullm  = (m_lvl == 256);
      emptym = (m_lvl == 0);
      cmp("level", 72'(ifc.level), 72'(m_lvl));
      cmp("full", 72'(ifc.full), 72'(fullm));
      cmp("empty", 72'(ifc.empty), 72'(emptym));
      cmp("rd_valid", 72'(ifc.rd_valid), 72'(!emptym));
      cmp("ovf_err", 72'(ifc.ovf_err), 72'(m_ovf));
      cmp("udf_err", 72'(ifc.udf_err), 72'(m_udf));
      cmp("rd_ram_addr", 72'(ifc.rd_ram_addr), 72'(m_rd % 256));
      cmp("wr_ram_addr", 72'(ifc.wr_ram_addr), 72'(m_wr % 256));
      ea = 1'b0; eb = 1'b0;
      if (!fullm && !ifc.flush) begin
        if (ifc.wr_req_a && ifc.wr_req_b) begin
          ea = m_last;
          eb = !m_last;
        end else begin
          ea = ifc.wr_req_a;
          eb = ifc.wr_req_b;
        end
      end
      cmp("wr_gnt_a", 72'(ifc.wr_gnt_a), 72'(ea));
      cmp("wr_gnt_b", 72'(ifc.wr_gnt_b), 72'(eb));
      cmp("wr_ram_enb", 72'(ifc.wr_ram_enb), 72'(ea | eb));
      if (ea || eb) cmp("wr_ram_data", ifc.wr_ram_data, ea ? ifc.wr_data_a : ifc.wr_data_b);
      rd = ifc.rd_ack && !emptym && !ifc.flush;
      if (rd) begin
        if (exp_q.size() == 0) begin
          cmp("scoreboard_underrun", 72'd1, 72'd0);
        end else begin
          front = exp_q.pop_front();
          cmp("rd_data", ifc.rd_data, front);
        end
      end
      if (ifc.flush) begin
        m_wr = 0; m_rd = 0; m_lvl = 0; m_ovf = 1'b0; m_udf = 1'b0;
        exp_q.delete();
      end else begin
        if (fullm && (ifc.wr_req_a || ifc.wr_req_b)) m_ovf = 1'b1;
        if (emptym && ifc.rd_ack) m_udf = 1'b1;
        if (ea || eb) begin
          exp_q.push_back(ea ? ifc.wr_data_a : ifc.wr_data_b);
          m_wr = m_wr + 1;
          m_last = eb;
          m_lvl = m_lvl + 1;
        end
        if (rd) begin
          m_rd = m_rd + 1;
          m_lvl = m_lvl - 1;
        end
      end
    end
  end

  task automatic drive(input logic a, input logic [71:0] da, input logic b,
                       input logic [71:0] db, input logic ack, input logic fl);
    @(posedge clk);
    #1;
    ifc.wr_req_a = a; ifc.wr_data_a = da;
    ifc.wr_req_b = b; ifc.wr_data_b = db;
    ifc.rd_ack = ack; ifc.flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 72'd0, 1'b0, 72'd0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    hc({tag, "_gnt_a"}, 72'(ifc.wr_gnt_a), 72'd0);
    hc({tag, "_gnt_b"}, 72'(ifc.wr_gnt_b), 72'd0);
    hc({tag, "_full"}, 72'(ifc.full), 72'd0);
    hc({tag, "_empty"}, 72'(ifc.empty), 72'd1);
    hc({tag, "_rd_valid"}, 72'(ifc.rd_valid), 72'd0);
    hc({tag, "_enb"}, 72'(ifc.wr_ram_enb), 72'd0);
    hc({tag, "_wr_addr"}, 72'(ifc.wr_ram_addr), 72'd0);
    hc({tag, "_rd_addr"}, 72'(ifc.rd_ram_addr), 72'd0);
    hc({tag, "_level"}, 72'(ifc.level), 72'd0);
    hc({tag, "_ovf"}, 72'(ifc.ovf_err), 72'd0);
    hc({tag, "_udf"}, 72'(ifc.udf_err), 72'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    ifc.wr_req_a = 1'b0; ifc.wr_req_b = 1'b0; ifc.rd_ack = 1'b0; ifc.flush = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic [3:0]  tie_a_pat;
  logic [71:0] rd_exp [3];

  initial begin
    tie_a_pat = 4'b0101;
    rd_exp[0] = 72'h11; rd_exp[1] = 72'h22; rd_exp[2] = 72'h33;
    reset_n = 1'b0;
    ifc.flush = 1'b0; ifc.rd_ack = 1'b0;
    ifc.wr_req_a = 1'b1; ifc.wr_data_a = 72'h99;
    ifc.wr_req_b = 1'b1; ifc.wr_data_b = 72'h98;
    #3;
    check_reset_outputs("rst");
    pulse_reset();

    // A alone writes three words, then they are read back in order
    drive(1'b1, 72'h11, 1'b0, 72'd0, 1'b0, 1'b0);
    hc("t1_gnt0", 72'(ifc.wr_gnt_a), 72'd1);
    hc("t1_empty_no_fallthrough", 72'(ifc.rd_valid), 72'd0);
    drive(1'b1, 72'h22, 1'b0, 72'd0, 1'b0, 1'b0);
    hc("t1_gnt1", 72'(ifc.wr_gnt_a), 72'd1);
    hc("t1_rd_valid_next", 72'(ifc.rd_valid), 72'd1);
    drive(1'b1, 72'h33, 1'b0, 72'd0, 1'b0, 1'b0);
    hc("t1_gnt2", 72'(ifc.wr_gnt_a), 72'd1);
    hc("t1_addr2", 72'(ifc.wr_ram_addr), 72'd2);
    idle();
    hc("t1_level3", 72'(ifc.level), 72'd3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 72'd0, 1'b0, 72'd0, 1'b1, 1'b0);
      hc("t1_rd_data", ifc.rd_data, rd_exp[i]);
    end
    idle();
    hc("t1_level0", 72'(ifc.level), 72'd0);
    hc("t1_empty", 72'(ifc.empty), 72'd1);

    // Both requesting: A, B, A, B at addresses 0..3, then A alone fills to 256
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 72'h0A00 + 72'(i), 1'b1, 72'h0B00 + 72'(i), 1'b0, 1'b0);
      hc("t2_gnt_a", 72'(ifc.wr_gnt_a), 72'(tie_a_pat[i]));
      hc("t2_gnt_b", 72'(ifc.wr_gnt_b), 72'(!tie_a_pat[i]));
      hc("t2_addr", 72'(ifc.wr_ram_addr), 72'(i));
    end
    for (int i = 4; i < 256; i++) drive(1'b1, 72'h0A00 + 72'(i), 1'b0, 72'd0, 1'b0, 1'b0);
    drive(1'b1, 72'h0E01, 1'b0, 72'd0, 1'b0, 1'b0);
    hc("t3_full", 72'(ifc.full), 72'd1);
    hc("t3_level256", 72'(ifc.level), 72'd256);
    hc("t3_no_gnt", 72'(ifc.wr_gnt_a), 72'd0);
    drive(1'b1, 72'h0E01, 1'b0, 72'd0, 1'b0, 1'b0);
    hc("t3_ovf", 72'(ifc.ovf_err), 72'd1);
    drive(1'b1, 72'h0E01, 1'b0, 72'd0, 1'b1, 1'b0);
    hc("t3_no_gnt_with_ack", 72'(ifc.wr_gnt_a), 72'd0);
    drive(1'b1, 72'h0E01, 1'b0, 72'd0, 1'b0, 1'b0);
    hc("t3_gnt_after_ack", 72'(ifc.wr_gnt_a), 72'd1);
    hc("t3_level255", 72'(ifc.level), 72'd255);
    idle();
    hc("t3_refull", 72'(ifc.full), 72'd1);
    for (int i = 0; i < 256; i++) drive(1'b0, 72'd0, 1'b0, 72'd0, 1'b1, 1'b0);
    idle();
    hc("t3_drained", 72'(ifc.empty), 72'd1);
    drive(1'b0, 72'd0, 1'b0, 72'd0, 1'b1, 1'b0);
    idle();
    hc("t3_udf", 72'(ifc.udf_err), 72'd1);
    hc("t3_udf_level0", 72'(ifc.level), 72'd0);

    // Flush at level 10 with both errors set
    for (int i = 0; i < 10; i++) drive(1'b1, 72'h0C00 + 72'(i), 1'b0, 72'd0, 1'b0, 1'b0);
    idle();
    hc("t6_level10", 72'(ifc.level), 72'd10);
    hc("t6_ovf_kept", 72'(ifc.ovf_err), 72'd1);
    hc("t6_udf_kept", 72'(ifc.udf_err), 72'd1);
    drive(1'b0, 72'd0, 1'b0, 72'd0, 1'b1, 1'b1);
    idle();
    hc("t6_level0", 72'(ifc.level), 72'd0);
    hc("t6_empty", 72'(ifc.empty), 72'd1);
    hc("t6_ovf0", 72'(ifc.ovf_err), 72'd0);
    hc("t6_udf0", 72'(ifc.udf_err), 72'd0);

    // Level 5 with simultaneous write and read
    for (int i = 0; i < 5; i++) drive(1'b1, 72'h0D00 + 72'(i), 1'b0, 72'd0, 1'b0, 1'b0);
    idle();
    hc("t4_level5", 72'(ifc.level), 72'd5);
    drive(1'b1, 72'h0D05, 1'b0, 72'd0, 1'b1, 1'b0);
    hc("t4_gnt", 72'(ifc.wr_gnt_a), 72'd1);
    hc("t4_rd_data", ifc.rd_data, 72'h0D00);
    idle();
    hc("t4_level_kept", 72'(ifc.level), 72'd5);
    hc("t4_wr_ptr", 72'(ifc.wr_ram_addr), 72'd6);
    hc("t4_rd_ptr", 72'(ifc.rd_ram_addr), 72'd1);
    for (int i = 0; i < 5; i++) drive(1'b0, 72'd0, 1'b0, 72'd0, 1'b1, 1'b0);

    // 300 words streamed through with a reader acking whenever data is shown
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      ifc.wr_req_a = 1'b1;
      ifc.wr_data_a = 72'h10000 + 72'(i);
      ifc.rd_ack = ifc.rd_valid;
      #1;
    end
    drive(1'b0, 72'd0, 1'b0, 72'd0, 1'b1, 1'b0);
    idle();
    hc("t5_level0", 72'(ifc.level), 72'd0);
    hc("t5_wr_wrap", 72'(ifc.wr_ram_addr), 72'd50);
    hc("t5_rd_wrap", 72'(ifc.rd_ram_addr), 72'd50);
    hc("t5_no_udf", 72'(ifc.udf_err), 72'd0);
    drive(1'b0, 72'd0, 1'b0, 72'd0, 1'b1, 1'b0);
    idle();
    hc("t5_udf", 72'(ifc.udf_err), 72'd1);
    hc("t5_udf_level0", 72'(ifc.level), 72'd0);

    // Asynchronous reset mid-fill
    for (int i = 0; i < 4; i++) drive(1'b1, 72'h0F00 + 72'(i), 1'b0, 72'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    ifc.wr_req_a = 1'b1; ifc.wr_data_a = 72'h0F04;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ifc.wr_req_a = 1'b0;
    idle();
    idle();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sdc_ram_fifo_ctrl.md
# sdc_ram_fifo_ctrl

Controller that runs the dual-port asynchronous distributed RAM as a circular FIFO shared by two write requesters. Port A is the SD-card data path and port B is the host/command path. It arbitrates the single RAM write port round-robin, owns the write and read pointers, and presents a show-ahead read interface to one consumer. It sits between the SD read datapath and the downstream packet/host logic, and is instantiated next to the RAM it drives.

## Interface
- RAM_WIDTH, 72, data bits per RAM row; must match the RAM instance.
- RAM_ADDR_BITS, 8, RAM address bits; depth = 2**RAM_ADDR_BITS.
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of FIFO contents.
- wr_req_a  in  1  requester A has a word to write.
- wr_data_a  in  RAM_WIDTH  requester A data.
- wr_gnt_a  out  1  A's word is written at this rising edge.
- wr_req_b  in  1  requester B has a word to write.
- wr_data_b  in  RAM_WIDTH  requester B data.
- wr_gnt_b  out  1  B's word is written at this rising edge.
- rd_valid  out  1  rd_data holds the oldest word.
- rd_data  out  RAM_WIDTH  oldest word; show-ahead.
- rd_ack  in  1  consumer takes rd_data at this edge.
- level  out  RAM_ADDR_BITS+1  words stored, range 0..2**RAM_ADDR_BITS.
- full  out  1  level equals depth.
- empty  out  1  level equals 0.
- ovf_err  out  1  sticky flag: a request arrived while full.
- udf_err  out  1  sticky flag: rd_ack arrived while empty.
- wr_ram_enb, wr_ram_addr[RAM_ADDR_BITS], wr_ram_data[RAM_WIDTH]  out  to the RAM write port.
- rd_ram_addr  out  RAM_ADDR_BITS  to the RAM read address.
- output_ram_data  in  RAM_WIDTH  RAM asynchronous read data.

## Operation
- State registers: wr_ptr and rd_ptr (RAM_ADDR_BITS wide), level (RAM_ADDR_BITS+1 wide), last_gnt (0 = A, 1 = B), ovf_err, udf_err.
- Arbitration is combinational from the current state.
  - No grant while full, flush, or reset_n is low.
  - Only one requester active: that requester is granted.
  - Both active: the requester not equal to last_gnt is granted.
  - At most one grant per cycle.
- Write path.
  - wr_ram_enb = wr_gnt_a | wr_gnt_b.
  - wr_ram_addr = wr_ptr.
  - wr_ram_data is taken from the granted port.
  - On each grant: wr_ptr increments and last_gnt takes the granted port.
- Read path.
  - rd_ram_addr = rd_ptr.
  - rd_data = output_ram_data.
  - rd_valid = !empty.
  - rd_ack with rd_valid high increments rd_ptr.
- Pointers wrap naturally from 2**RAM_ADDR_BITS-1 to 0.
- level update rule:
  - write only: level + 1;
  - read only: level - 1;
  - write and read in the same cycle: level unchanged.
- Full with rd_ack in the same cycle: no write grant. The freed slot becomes available the next cycle.
- Empty with a write in the same cycle: rd_valid stays low that cycle and rises the next cycle. No fall-through.
- Error flags.
  - ovf_err sets when any wr_req_x is high while full.
  - udf_err sets when rd_ack is high while empty; pointers and level are unchanged.
  - Both flags clear only on reset or flush.
- flush: the next edge zeroes wr_ptr, rd_ptr, level, ovf_err and udf_err. A same-cycle rd_ack is ignored. last_gnt is kept.

## Timing
- Reset values: wr_ptr 0, rd_ptr 0, level 0, last_gnt 1 (so A wins the first tie), ovf_err 0, udf_err 0.
- Output values during reset: full 0, empty 1, rd_valid 0, wr_gnt_a/b 0, wr_ram_enb 0, wr_ram_addr 0, rd_ram_addr 0.
- Assertion of reset_n low mid-operation clears state immediately. Stored data is abandoned.
- Grants are same-cycle: the requester holds its data valid while wr_req is high and treats grant high as written.
- Write-to-read latency is 1 cycle. Data written at edge N is readable after edge N (rd_valid high in cycle N+1).
- Sustained throughput is one write and one read per cycle.

## Test plan
- Reset, then A alone writes 0x11, 0x22, 0x33 -> wr_gnt_a high 3 cycles; rd_data reads 0x11, 0x22, 0x33 with acks; level ends at 0 and empty=1.
- A and B request continuously with an idle reader -> grants alternate A, B, A, B starting with A; wr_ram_addr runs 0, 1, 2, 3.
- Fill 256 words (default parameters) -> full=1 and level=256 with no grant; a further request sets ovf_err. One rd_ack then allows one grant the following cycle.
- Steady state at level 5 with a write and an rd_ack in the same cycle -> level stays 5; wr_ptr and rd_ptr both advance.
- Write 300 words while reading continuously -> pointers wrap past 255 to 0 and data order is preserved. rd_ack while empty sets udf_err and leaves level at 0.
- flush at level 10 with errors set -> the next cycle shows level 0, empty 1, both errors 0. Assert reset_n low mid-fill -> outputs return to reset values asynchronously.
